// File: rtl/seg7_capture_if.sv
// rtl/seg7_capture_if.sv - display-bus sample inputs and decoded frame outputs of seg7_capture
interface seg7_capture_if #(
  parameter int NDIG = 8
);
  logic [7:0]        seg;
  logic [NDIG-1:0]   an;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   blank_mask;
  logic [NDIG-1:0]   dp_mask;
  logic [NDIG-1:0]   err_mask;
  logic              frame_valid;

  modport master (
    output seg, an,
    input  value, blank_mask, dp_mask, err_mask, frame_valid
  );

  modport slave (
    input  seg, an,
    output value, blank_mask, dp_mask, err_mask, frame_valid
  );
endinterface

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - multiplexed 7-segment display readback monitor
module seg7_capture #(
  parameter int NDIG   = 8,
  parameter int STABLE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_capture_if.slave bus
);

  localparam logic [7:0] STABLE_C = 8'(STABLE);

  logic [NDIG-1:0]        prev_an_q, prev_an_d;
  logic [7:0]             prev_seg_q, prev_seg_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [NDIG-1:0]        seen_q, seen_d;
  logic [NDIG-1:0][3:0]   stage_nib_q, stage_nib_d;
  logic [NDIG-1:0]        stage_blank_q, stage_blank_d;
  logic [NDIG-1:0]        stage_dp_q, stage_dp_d;
  logic [NDIG-1:0]        stage_err_q, stage_err_d;
  logic [4*NDIG-1:0]      value_q, value_d;
  logic [NDIG-1:0]        blank_q, blank_d;
  logic [NDIG-1:0]        dp_q, dp_d;
  logic [NDIG-1:0]        err_q, err_d;
  logic                   fv_q, fv_d;

  logic [NDIG-1:0] sel;
  logic            valid;
  logic            same;
  logic            capture;
  logic [3:0]      dec_nib;
  logic            dec_blank;
  logic            dec_err;

  assign sel = ~bus.an;

  // Glyph decode on active-high abcdefg.
  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (~bus.seg[7:1])
      7'b1111110: dec_nib = 4'h0;
      7'b0110000: dec_nib = 4'h1;
      7'b1101101: dec_nib = 4'h2;
      7'b1111001: dec_nib = 4'h3;
      7'b0110011: dec_nib = 4'h4;
      7'b1011011: dec_nib = 4'h5;
      7'b1011111: dec_nib = 4'h6;
      7'b1110000: dec_nib = 4'h7;
      7'b1111111: dec_nib = 4'h8;
      7'b1111011: dec_nib = 4'h9;
      7'b1110111: dec_nib = 4'hA;
      7'b0011111: dec_nib = 4'hB;
      7'b1001110: dec_nib = 4'hC;
      7'b0111101: dec_nib = 4'hD;
      7'b1001111: dec_nib = 4'hE;
      7'b1000111: dec_nib = 4'hF;
      7'b0000000: dec_blank = 1'b1;
      default:    dec_err = 1'b1;
    endcase
  end

  always_comb begin
    prev_an_d     = bus.an;
    prev_seg_d    = bus.seg;
    cnt_d         = cnt_q;
    seen_d        = seen_q;
    stage_nib_d   = stage_nib_q;
    stage_blank_d = stage_blank_q;
    stage_dp_d    = stage_dp_q;
    stage_err_d   = stage_err_q;
    value_d       = value_q;
    blank_d       = blank_q;
    dp_d          = dp_q;
    err_d         = err_q;
    fv_d          = 1'b0;

    valid = (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);
    same  = (bus.an == prev_an_q) && (bus.seg == prev_seg_q);

    if (!valid)
      cnt_d = 8'd0;
    else if (!same)
      cnt_d = 8'd1;
    else if (cnt_q < STABLE_C)
      cnt_d = cnt_q + 8'd1;

    // A saturated counter holding the same sample must not recapture.
    capture = valid && (cnt_d == STABLE_C) && !(same && (cnt_q == STABLE_C));

    // Publish reads the pre-capture staging; the capture then starts the next frame.
    if (&seen_q) begin
      value_d = stage_nib_q;
      blank_d = stage_blank_q;
      dp_d    = stage_dp_q;
      err_d   = stage_err_q;
      fv_d    = 1'b1;
      seen_d  = '0;
    end

    if (capture) begin
      for (int i = 0; i < NDIG; i++) begin
        if (sel[i]) begin
          stage_nib_d[i]   = dec_nib;
          stage_blank_d[i] = dec_blank;
          stage_dp_d[i]    = ~bus.seg[0];
          stage_err_d[i]   = dec_err;
          seen_d[i]        = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_an_q     <= '1;
      prev_seg_q    <= 8'hFF;
      cnt_q         <= 8'd0;
      seen_q        <= '0;
      stage_nib_q   <= '0;
      stage_blank_q <= '0;
      stage_dp_q    <= '0;
      stage_err_q   <= '0;
      value_q       <= '0;
      blank_q       <= '1;
      dp_q          <= '0;
      err_q         <= '0;
      fv_q          <= 1'b0;
    end else begin
      prev_an_q     <= prev_an_d;
      prev_seg_q    <= prev_seg_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      stage_nib_q   <= stage_nib_d;
      stage_blank_q <= stage_blank_d;
      stage_dp_q    <= stage_dp_d;
      stage_err_q   <= stage_err_d;
      value_q       <= value_d;
      blank_q       <= blank_d;
      dp_q          <= dp_d;
      err_q         <= err_d;
      fv_q          <= fv_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.blank_mask  = blank_q;
  assign bus.dp_mask     = dp_q;
  assign bus.err_mask    = err_q;
  assign bus.frame_valid = fv_q;

endmodule
